cxl_mem_responder: RTL

CXL_MEM_RESPONDER -- requirements
Module: cxl_mem_responder

---
 rtl/cxl_mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cxl_mem_responder.sv
// cxl_mem_responder: line-addressed store with fixed-latency in-order responses, back-pressure and an invalidation FSM
module cxl_mem_responder #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 512,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int INV_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_err,
    input  logic                    inv_valid,
    output logic                    inv_ready,
    input  logic [ADDR_WIDTH-1:0]   inv_addr,
    output logic [15:0]             inv_count
);
    localparam int IDX_W = DEPTH_LINES > 1 ? $clog2(DEPTH_LINES) : 1;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = INV_CYCLES > 0 ? $clog2(INV_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH_LINES) << 6;
    localparam logic [0:0] INV_IDLE = 1'b0;
    localparam logic [0:0] INV_BUSY = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH_LINES];
    logic [IDX_W-1:0]      idx;
    logic                  oor, accept, pop, push;
    logic [DATA_WIDTH-1:0] line, merged, resp_d;
    logic                  pv [LATENCY];
    logic [DATA_WIDTH-1:0] pd [LATENCY];
    logic                  pe [LATENCY];
    logic [DATA_WIDTH-1:0] fd [FIFO_DEPTH];
    logic                  fe [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [OW-1:0]         fcnt, outstanding;
    logic [0:0]            state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] inv_addr_unused;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign idx        = req_addr[6 +: IDX_W];
    assign oor        = req_addr >= LIMIT;
    assign line       = mem[idx];
    assign accept     = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;
    assign push       = pv[LATENCY-1];
    assign resp_d     = oor ? '0 : (req_write ? merged : line);
    // outstanding covers pipeline + FIFO, so admitting below FIFO_DEPTH can never overflow
    assign req_ready  = rst_n && (outstanding < OW'(FIFO_DEPTH));
    assign resp_valid = fcnt != '0;
    assign resp_data  = resp_valid ? fd[rptr] : '0;
    assign resp_err   = resp_valid && fe[rptr];
    assign inv_ready  = rst_n && state == INV_IDLE;

    always_comb begin
        merged = line;
        for (int i = 0; i < DATA_WIDTH/8; i++)
            merged[8*i +: 8] = req_strb[i] ? req_data[8*i +: 8] : line[8*i +: 8];
    end

    always_ff @(posedge clk)
        if (accept && req_write && !oor) mem[idx] <= merged;

    always_ff @(posedge clk) begin
        pd[0] <= resp_d;
        pe[0] <= oor;
        for (int i = 1; i < LATENCY; i++) begin
            pd[i] <= pd[i-1];
            pe[i] <= pe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            fd[wptr] <= pd[LATENCY-1];
            fe[wptr] <= pe[LATENCY-1];
        end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            fcnt        <= '0;
            outstanding <= '0;
        end else begin
            wptr        <= push ? nxt(wptr) : wptr;
            rptr        <= pop ? nxt(rptr) : rptr;
            fcnt        <= fcnt + OW'(push) - OW'(pop);
            outstanding <= outstanding + OW'(accept) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INV_IDLE;
            cnt       <= '0;
            inv_count <= '0;
        end else if (inv_valid && inv_ready) begin
            state     <= INV_BUSY;
            cnt       <= CW'(INV_CYCLES);
            inv_count <= inv_count + 16'(inv_count != 16'hFFFF);
        end else if (state == INV_BUSY) begin
            state <= cnt > CW'(1) ? INV_BUSY : INV_IDLE;
            cnt   <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (inv_valid && inv_ready) inv_addr_unused <= inv_addr;
endmodule
